// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of the write-back arbiter's bus signals.
//  Pipeline result : pipeValid, pipeWe, pipeRd, pipeData
//  LLU issue       : issueValid, issueRd
//  LLU result      : lluValid, lluRd, lluData, lluReady (back-pressure)
//  Register file   : rd, rdData, we
//  Hazard/status   : pendingMask, stallReq
// The slave modport is the arbiter; the master modport is the surrounding core.
interface wb_arbiter_if;
    logic        pipeValid;
    logic        pipeWe;
    logic [4:0]  pipeRd;
    logic [31:0] pipeData;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        lluValid;
    logic [4:0]  lluRd;
    logic [31:0] lluData;
    logic        lluReady;
    logic [4:0]  rd;
    logic [31:0] rdData;
    logic        we;
    logic [31:0] pendingMask;
    logic        stallReq;

    modport slave (
        input  pipeValid, pipeWe, pipeRd, pipeData,
        input  issueValid, issueRd,
        input  lluValid, lluRd, lluData,
        output lluReady, rd, rdData, we, pendingMask, stallReq
    );

    modport master (
        output pipeValid, pipeWe, pipeRd, pipeData,
        output issueValid, issueRd,
        output lluValid, lluRd, lluData,
        input  lluReady, rd, rdData, we, pendingMask, stallReq
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage driving the register file's single write port.
//  The in-order pipeline result always wins the port; long-latency unit (LLU)
//  results wait in a small FIFO and are written in cycles the pipeline leaves
//  free. A scoreboard tracks registers with an LLU write outstanding, and a
//  starvation counter asks the pipeline for a bubble when the FIFO stays full.
// Ports:
//  clk  - clock, all state on posedge
//  rst  - asynchronous active-high reset
//  bus  - wb_arbiter_if.slave (pipeline/LLU inputs, register-file write port,
//         lluReady back-pressure, pendingMask scoreboard, stallReq)
module wb_arbiter #(
    parameter int LLU_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (LLU_DEPTH > 1) ? $clog2(LLU_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LLU_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    logic [4:0]       fifo_rd_r   [LLU_DEPTH];
    logic [31:0]      fifo_data_r [LLU_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [4:0]       rd_r;
    logic [31:0]      rd_data_r;
    logic             we_r;
    logic [31:0]      mask_r;
    logic [31:0]      mask_clr_s;
    logic [31:0]      mask_nxt_s;
    logic [STV_W-1:0] starve_r;
    logic [STV_W-1:0] starve_nxt_s;
    logic             full_s;
    logic             pw_s;
    logic             push_s;
    logic             pop_s;
    logic [4:0]       head_rd_s;
    logic [31:0]      head_data_s;

    // Fullness is taken from the start-of-cycle count, so a same-cycle pop
    // never opens a slot for a push in that cycle.
    assign full_s      = (count_r == FULL_CNT);
    assign pw_s        = bus.pipeValid & bus.pipeWe & (bus.pipeRd != 5'd0);
    // Results for x0 are handshaken but dropped, keeping rd=0 out of the FIFO.
    assign push_s      = bus.lluValid & ~full_s & (bus.lluRd != 5'd0);
    assign pop_s       = ~pw_s & (count_r != {CNT_W{1'b0}});
    assign head_rd_s   = fifo_rd_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    assign bus.lluReady    = ~full_s;
    assign bus.rd          = rd_r;
    assign bus.rdData      = rd_data_r;
    assign bus.we          = we_r;
    assign bus.pendingMask = mask_r;
    assign bus.stallReq    = (starve_r == STARVE_MAX);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Scoreboard update: clear on LLU pop first, then set on issue so set wins.
    always_comb begin
        mask_clr_s = mask_r;
        if (pop_s) begin
            mask_clr_s[head_rd_s] = 1'b0;
        end else begin
            mask_clr_s = mask_r;
        end
        mask_nxt_s = mask_clr_s;
        if (bus.issueValid && (bus.issueRd != 5'd0)) begin
            mask_nxt_s[bus.issueRd] = 1'b1;
        end else begin
            mask_nxt_s = mask_clr_s;
        end
    end

    // Starvation counter: counts consecutive full+pipeline-write cycles, saturating.
    always_comb begin
        starve_nxt_s = {STV_W{1'b0}};
        if (full_s && pw_s) begin
            if (starve_r == STARVE_MAX) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + STV_W'(1);
            end
        end else begin
            starve_nxt_s = {STV_W{1'b0}};
        end
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LLU_DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_rd_r[wr_ptr_r]   <= bus.lluRd;
                fifo_data_r[wr_ptr_r] <= bus.lluData;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Register-file write port: pipeline first, then FIFO head, else idle (hold rd/rdData).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r      <= 1'b0;
            rd_r      <= 5'd0;
            rd_data_r <= 32'd0;
        end else if (pw_s) begin
            we_r      <= 1'b1;
            rd_r      <= bus.pipeRd;
            rd_data_r <= bus.pipeData;
        end else if (pop_s) begin
            we_r      <= 1'b1;
            rd_r      <= head_rd_s;
            rd_data_r <= head_data_s;
        end else begin
            we_r <= 1'b0;
        end
    end

    // Scoreboard and starvation state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r   <= 32'd0;
            starve_r <= {STV_W{1'b0}};
        end else begin
            mask_r   <= mask_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if intf ();

    wb_arbiter #(.LLU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    // Reference model: LLU results waiting for the port, and expected outputs.
    logic [36:0] q[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_mask;
    int          m_starve;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_mask = 32'd0; m_starve = 0;
    endtask

    task automatic idle();
        intf.pipeValid = 1'b0; intf.pipeWe = 1'b0; intf.pipeRd = 5'd0; intf.pipeData = 32'd0;
        intf.issueValid = 1'b0; intf.issueRd = 5'd0;
        intf.lluValid = 1'b0; intf.lluRd = 5'd0; intf.lluData = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] r, input logic [31:0] d);
        intf.pipeValid = 1'b1; intf.pipeWe = 1'b1; intf.pipeRd = r; intf.pipeData = d;
    endtask

    task automatic drive_llu(input logic [4:0] r, input logic [31:0] d);
        intf.lluValid = 1'b1; intf.lluRd = r; intf.lluData = d;
    endtask

    // One clock: check status outputs before the edge, advance the model, check the write port after.
    task automatic step();
        bit full, pw, push, pop;
        logic [36:0] head;
        #1;
        full = (q.size() == DEPTH);
        chk("lluReady", {31'd0, intf.lluReady}, {31'd0, !full});
        chk("stallReq", {31'd0, intf.stallReq}, {31'd0, m_starve == LIMIT});
        chk("pendingMask", intf.pendingMask, m_mask);
        pw   = intf.pipeValid && intf.pipeWe && (intf.pipeRd != 5'd0);
        push = intf.lluValid && !full && (intf.lluRd != 5'd0);
        pop  = !pw && (q.size() > 0);
        if (pw) begin
            m_we = 1'b1; m_rd = intf.pipeRd; m_data = intf.pipeData;
        end else if (pop) begin
            head = q.pop_front();
            m_we = 1'b1; m_rd = head[36:32]; m_data = head[31:0];
            m_mask[head[36:32]] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (push) q.push_back({intf.lluRd, intf.lluData});
        if (intf.issueValid && intf.issueRd != 5'd0) m_mask[intf.issueRd] = 1'b1;
        if (full && pw) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else m_starve = 0;
        @(posedge clk);
        #1;
        chk("we", {31'd0, intf.we}, {31'd0, m_we});
        chk("rd", {27'd0, intf.rd}, {27'd0, m_rd});
        chk("rdData", intf.rdData, m_data);
        chk("we_rd_nonzero", {31'd0, intf.we && (intf.rd == 5'd0)}, 32'd0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_we", {31'd0, intf.we}, 32'd0);
        chk("rst_rd", {27'd0, intf.rd}, 32'd0);
        chk("rst_rdData", intf.rdData, 32'd0);
        chk("rst_mask", intf.pendingMask, 32'd0);
        chk("rst_lluReady", {31'd0, intf.lluReady}, 32'd1);
        chk("rst_stallReq", {31'd0, intf.stallReq}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] r;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // 1: pipeline write x5, visible one cycle later, then idle.
        idle(); step();
        idle(); step();
        drive_pipe(5'd5, 32'hDEADBEEF); step();
        chk("t1_we", {31'd0, intf.we}, 32'd1);
        chk("t1_rd", {27'd0, intf.rd}, 32'd5);
        chk("t1_data", intf.rdData, 32'hDEADBEEF);
        idle(); step();
        chk("t1_we_low", {31'd0, intf.we}, 32'd0);

        // 2: issue x7, LLU result x7 pushed, popped next cycle.
        idle(); intf.issueValid = 1'b1; intf.issueRd = 5'd7; step();
        idle(); drive_llu(5'd7, 32'h11); step();
        chk("t2_pend_before", {31'd0, intf.pendingMask[7]}, 32'd1);
        idle(); step();
        chk("t2_rd", {27'd0, intf.rd}, 32'd7);
        chk("t2_data", intf.rdData, 32'h11);
        chk("t2_pend_after", {31'd0, intf.pendingMask[7]}, 32'd0);

        // 3: simultaneous pipeline x3 and LLU x4; pipeline first.
        idle(); drive_pipe(5'd3, 32'h3333); drive_llu(5'd4, 32'h4444); step();
        idle(); step();
        chk("t3_rd_llu", {27'd0, intf.rd}, 32'd4);

        // 4: fill the FIFO under continuous pipeline writes, starve, then bubble.
        idle(); drive_pipe(5'd1, 32'hA0); drive_llu(5'd10, 32'hB0); step();
        idle(); drive_pipe(5'd2, 32'hA1); drive_llu(5'd11, 32'hB1); step();
        for (int i = 0; i < LIMIT; i++) begin
            idle(); drive_pipe(5'(12 + i), 32'(i)); drive_llu(5'd20, 32'hB2); step();
        end
        #1;
        chk("t4_stallReq", {31'd0, intf.stallReq}, 32'd1);
        chk("t4_lluReady", {31'd0, intf.lluReady}, 32'd0);
        idle(); step();
        chk("t4_drain_rd", {27'd0, intf.rd}, 32'd10);
        idle(); step();
        idle(); step();

        // 5: issue x9 in the same cycle its result pops; x0 result is dropped.
        idle(); intf.issueValid = 1'b1; intf.issueRd = 5'd9; step();
        idle(); drive_llu(5'd9, 32'h99); step();
        idle(); intf.issueValid = 1'b1; intf.issueRd = 5'd9; step();
        chk("t5_pend9", {31'd0, intf.pendingMask[9]}, 32'd1);
        idle(); drive_llu(5'd0, 32'h77); step();
        idle(); step();
        chk("t5_x0_no_write", {31'd0, intf.we}, 32'd0);

        // 6: reset with a full FIFO and pending bits, then no stale write.
        idle(); intf.issueValid = 1'b1; intf.issueRd = 5'd15;
        drive_pipe(5'd6, 32'h6); drive_llu(5'd15, 32'hF0); step();
        idle(); drive_pipe(5'd6, 32'h7); drive_llu(5'd16, 32'hF1); step();
        pulse_reset();
        idle(); step();
        idle(); step();
        chk("t6_no_stale", {31'd0, intf.we}, 32'd0);

        // Randomised traffic against the model, with one reset mid-run.
        for (int n = 0; n < 400; n++) begin
            idle();
            if (m_starve != LIMIT && ($urandom_range(3) != 0)) begin
                intf.pipeValid = 1'b1;
                intf.pipeWe    = 1'($urandom_range(3) != 0);
                intf.pipeRd    = 5'($urandom_range(31));
                intf.pipeData  = $urandom;
            end
            if ($urandom_range(2) == 0) begin
                r = 5'($urandom_range(31));
                if (!m_mask[r]) begin
                    intf.issueValid = 1'b1; intf.issueRd = r;
                end
            end
            if ($urandom_range(1) == 0) drive_llu(5'($urandom_range(31)), $urandom);
            if (n == 200) pulse_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
